// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: owns baud timing, frame sequencing and serialisation, with per-frame
// divisor, data length, parity mode and stop-bit count latched at the valid/ready handshake.
module uart_tx_frame_engine #(
    parameter int unsigned  DIV_W  = 16,
    parameter int unsigned  DATA_W = 8,
    localparam int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              tx_arst_n,
    input  logic              tx_rst_i,
    input  logic              tx_en_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [LEN_W-1:0]  cfg_data_len_i,
    input  logic [1:0]        cfg_parity_i,
    input  logic              cfg_stop2_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_line_o,
    output logic              bit_tick_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d, div_q;
    logic [DATA_W-1:0]  shift_q, shift_d, data_masked;
    logic [LEN_W-1:0]   len_q, idx_q, idx_d, eff_len;
    logic               par_en_q, par_bit_q, stop2_q;
    logic               stop_second_q, stop_second_d;
    logic               line_q, line_d, busy_q, busy_d, done_q, done_d;
    logic               run, accept, last_stop;

    always_comb begin : cfg_decode
        eff_len = cfg_data_len_i;
        if (cfg_data_len_i == '0 || cfg_data_len_i > LEN_W'(DATA_W)) begin
            eff_len = LEN_W'(DATA_W);
        end
        for (int i = 0; i < DATA_W; i++) begin
            data_masked[i] = tx_data_i[i] & (LEN_W'(i) < eff_len);
        end
    end

    assign run        = tx_en_i & ~tx_rst_i;
    assign bit_tick_o = (state_q != StIdle) && (cnt_q == div_q);
    // Last cycle of the final stop bit: the only mid-frame point where a new word may enter.
    assign last_stop  = (state_q == StStop) && bit_tick_o && (!stop2_q || stop_second_q);
    assign tx_ready_o = run && ((state_q == StIdle) || last_stop);
    assign accept     = tx_valid_i && tx_ready_o;

    always_ff @(posedge clk or negedge tx_arst_n) begin : state_reg
        if (!tx_arst_n) begin
            state_q <= StIdle;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (!run) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = StStart;
        end else if (bit_tick_o) begin
            case (state_q)
                StStart:  state_d = StData;
                StData: begin
                    if (idx_q == len_q - LEN_W'(1)) state_d = par_en_q ? StParity : StStop;
                end
                StParity: state_d = StStop;
                StStop: begin
                    if (last_stop) state_d = StIdle;
                end
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin : datapath_next
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        stop_second_d = stop_second_q;
        if (!run) begin
            cnt_d         = '0;
            idx_d         = '0;
            stop_second_d = 1'b0;
        end else if (accept) begin
            cnt_d         = '0;
            idx_d         = '0;
            shift_d       = data_masked;
            stop_second_d = 1'b0;
        end else if (bit_tick_o) begin
            cnt_d = '0;
            if (state_q == StData) begin
                idx_d   = idx_q + LEN_W'(1);
                shift_d = shift_q >> 1;
            end
            if (state_q == StStop) stop_second_d = 1'b1;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Line is registered from the next state so it changes on the very edge the bit begins.
    always_comb begin : outputs_next
        case (state_d)
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_d[0];
            StParity: line_d = par_bit_q;
            default:  line_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = run && last_stop;
    end

    always_ff @(posedge clk or negedge tx_arst_n) begin : datapath_reg
        if (!tx_arst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            stop_second_q <= 1'b0;
            div_q         <= '0;
            len_q         <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            stop_second_q <= stop_second_d;
            if (accept) begin
                div_q     <= baud_div_i;
                len_q     <= eff_len;
                par_en_q  <= (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
                par_bit_q <= (^data_masked) ^ (cfg_parity_i == 2'b10);
                stop2_q   <= cfg_stop2_i;
            end
        end
    end

    assign tx_line_o = line_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: expected line bits are queued when a word is
// offered and compared cycle by cycle as the frame is shifted out.
module tb_uart_tx_frame_engine;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              tx_arst_n;
    logic              tx_rst;
    logic              tx_en;
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        cfg_data_len;
    logic [1:0]        cfg_parity;
    logic              cfg_stop2;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_line;
    logic              bit_tick;
    logic              busy;
    logic              done;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame_engine #(
        .DIV_W (DIV_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .tx_arst_n     (tx_arst_n),
        .tx_rst_i      (tx_rst),
        .tx_en_i       (tx_en),
        .baud_div_i    (baud_div),
        .cfg_data_len_i(cfg_data_len),
        .cfg_parity_i  (cfg_parity),
        .cfg_stop2_i   (cfg_stop2),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .tx_line_o     (tx_line),
        .bit_tick_o    (bit_tick),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Reference frame: start, N data bits LSB first, optional parity, one or two stops.
    function automatic int push_frame(input logic [7:0] d, input int len, input logic [1:0] par,
                                      input logic s2);
        int   n;
        logic ones;
        n    = (len == 0 || len > 8) ? 8 : len;
        ones = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones ^= d[i];
        end
        if (par == 2'b01) exp_q.push_back(ones);
        else if (par == 2'b10) exp_q.push_back(~ones);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
        return 1 + n + ((par == 2'b01 || par == 2'b10) ? 1 : 0) + (s2 ? 2 : 1);
    endfunction

    // Called at a negedge; returns at the negedge inside cycle 0 of the accepted frame.
    task automatic offer(input logic [7:0] d, input int len, input logic [1:0] par,
                         input logic s2, input int div, input bit hold, output int nbits);
        tx_data      = d;
        cfg_data_len = 4'(len);
        cfg_parity   = par;
        cfg_stop2    = s2;
        baud_div     = DIV_W'(div);
        tx_valid     = 1'b1;
        nbits        = push_frame(d, len, par, s2);
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL offer_ready got %b want 1", tx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic check_bits(input int nbits, input int div, input bit done_first,
                              input string tag);
        logic e;
        for (int b = 0; b < nbits; b++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty at bit %0d", tag, b);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c <= div; c++) begin
                checks++;
                if (tx_line !== e) begin
                    errors++;
                    $display("FAIL %s line bit %0d cyc %0d got %b want %b", tag, b, c, tx_line, e);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy bit %0d cyc %0d got %b want 1", tag, b, c, busy);
                end
                checks++;
                if (bit_tick !== (c == div)) begin
                    errors++;
                    $display("FAIL %s tick bit %0d cyc %0d got %b want %b", tag, b, c, bit_tick,
                             (c == div));
                end
                checks++;
                if (done !== (done_first && b == 0 && c == 0)) begin
                    errors++;
                    $display("FAIL %s done bit %0d cyc %0d got %b want %b", tag, b, c, done,
                             (done_first && b == 0 && c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_end(input string tag);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_line !== 1'b1) begin
            errors++;
            $display("FAIL %s end done/busy/line got %b%b%b want 101", tag, done, busy, tx_line);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width got %b want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        int nb;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bit_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state line/busy/done/tick got %b%b%b%b want 1000",
                     tx_line, busy, done, bit_tick);
        end
        tx_arst_n = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", tx_ready);
        end
        @(negedge clk);
        offer(8'hA5, 8, 2'b00, 1'b0, 3, 1'b0, nb);
        check_bits(3, 3, 1'b0, "pre_reset");
        tx_arst_n = 1'b0;
        #1;
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset line/busy/done got %b%b%b want 100", tx_line, busy, done);
        end
        exp_q.delete();
        @(negedge clk);
        tx_arst_n = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_ready ready/busy got %b%b want 10", tx_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_8n1();
        int nb;
        offer(8'hA5, 8, 2'b00, 1'b0, 3, 1'b0, nb);
        check_bits(nb, 3, 1'b0, "8n1");
        check_end("8n1");
    endtask

    task automatic test_7e2();
        int nb;
        // Bit 7 set but beyond the 7-bit length, so it must not appear or affect parity.
        offer(8'hB5, 7, 2'b01, 1'b1, 0, 1'b0, nb);
        check_bits(nb, 0, 1'b0, "7e2");
        check_end("7e2");
    endtask

    task automatic test_back_to_back();
        int nb1;
        int nb2;
        offer(8'h1F, 5, 2'b10, 1'b0, 1, 1'b1, nb1);
        tx_data = 8'h00;
        nb2     = push_frame(8'h00, 5, 2'b10, 1'b0);
        check_bits(nb1, 1, 1'b0, "b2b_first");
        tx_valid = 1'b0;
        check_bits(nb2, 1, 1'b1, "b2b_second");
        check_end("b2b");
    endtask

    task automatic test_abort(input bit use_rst);
        int   nb;
        logic e;
        offer(8'hA5, 8, 2'b00, 1'b0, 3, 1'b0, nb);
        check_bits(4, 3, 1'b0, "abort_pre");
        e = exp_q[0];
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (tx_line !== e) begin
                errors++;
                $display("FAIL abort_bit3 cyc %0d got %b want %b", c, tx_line, e);
            end
            @(negedge clk);
        end
        if (use_rst) begin
            tx_rst   = 1'b1;
            tx_valid = 1'b1;
            #1;
            checks++;
            if (tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_ready got %b want 0", tx_ready);
            end
        end else begin
            tx_en = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge rst=%0d line/busy/done got %b%b%b want 100",
                     use_rst, tx_line, busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold rst=%0d busy got %b want 0", use_rst, busy);
        end
        tx_valid = 1'b0;
        tx_rst   = 1'b0;
        tx_en    = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || tx_line !== 1'b1) begin
                errors++;
                $display("FAIL abort_no_done rst=%0d cyc %0d done/line got %b%b want 01",
                         use_rst, c, done, tx_line);
            end
        end
    endtask

    task automatic test_done_abort();
        int nb;
        offer(8'h00, 8, 2'b00, 1'b0, 0, 1'b0, nb);
        check_bits(nb - 1, 0, 1'b0, "done_abort_pre");
        checks++;
        if (tx_line !== 1'b1 || bit_tick !== 1'b1) begin
            errors++;
            $display("FAIL done_abort_stop line/tick got %b%b want 11", tx_line, bit_tick);
        end
        tx_en = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_abort done/busy got %b%b want 00", done, busy);
        end
        tx_en = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_config_isolation();
        int nb;
        offer(8'h5A, 8, 2'b01, 1'b0, 3, 1'b0, nb);
        baud_div     = DIV_W'(9);
        cfg_parity   = 2'b10;
        cfg_data_len = 4'd3;
        cfg_stop2    = 1'b1;
        check_bits(nb, 3, 1'b0, "iso_first");
        check_end("iso_first");
        offer(8'hC3, 0, 2'b10, 1'b0, 9, 1'b0, nb);
        check_bits(nb, 9, 1'b0, "iso_second");
        check_end("iso_second");
        offer(8'h81, 12, 2'b00, 1'b0, 0, 1'b0, nb);
        check_bits(nb, 0, 1'b0, "len_clamp");
        check_end("len_clamp");
    endtask

    initial begin
        tx_arst_n    = 1'b0;
        tx_rst       = 1'b0;
        tx_en        = 1'b1;
        tx_valid     = 1'b0;
        tx_data      = '0;
        baud_div     = '0;
        cfg_data_len = '0;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        test_reset();
        test_8n1();
        test_7e2();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_done_abort();
        test_config_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_engine.md
# uart_tx_frame_engine

Runtime-configurable UART transmit engine. It replaces the fixed-rate, fixed-10-bit-frame transmit baud counter with a single block that owns the baud timing, frame sequencing and serialisation. Baud divisor, data length, parity mode and stop-bit count are programmable per frame. A valid/ready handshake on the parallel side allows back-to-back frames with no idle gap. The block sits between the TX register interface and the `tx` pad.

## Interface
- `DIV_W`, 16: width of the baud divisor. One bit period is `baud_div+1` clocks.
- `DATA_W`, 8: maximum data bits per frame and the width of `tx_data`.
- `clk` in 1: clock.
- `tx_arst_n` in 1: reset, asynchronous, active-low.
- `tx_rst` in 1: synchronous clear, equivalent to async reset but sampled on `clk`.
- `tx_en` in 1: enable. Low forces IDLE and aborts any frame in progress.
- `baud_div` in DIV_W: bit period minus one.
- `cfg_data_len` in $clog2(DATA_W+1): data bits per frame, legal range 1..DATA_W. 0 or a value above DATA_W is treated as DATA_W.
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 0 gives one stop bit, 1 gives two.
- `tx_data` in DATA_W: payload, sent LSB first. Bits above the data length are ignored.
- `tx_valid` in 1: payload offered.
- `tx_ready` out 1: engine accepts the payload this cycle.
- `tx_line` out 1: serial output, idles high.
- `bit_tick` out 1: pulses in the last cycle of every bit period.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse after each completed frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- All outputs except `tx_ready` and `bit_tick` are registered.
- Reset (async or `tx_rst`) produces: state IDLE, `tx_line`=1, `busy`=0, `done`=0, bit counter 0, data index 0, `bit_tick`=0.
- `tx_ready` = `tx_en` & ~`tx_rst` & (state==IDLE | last cycle of final stop bit). It is combinational.
- Accept: `tx_valid` & `tx_ready` at an edge.
  - At that edge, latch `tx_data`, `baud_div`, the effective data length, `cfg_parity` and `cfg_stop2`.
  - At that edge, go to START and clear the bit counter.
  - Configuration changes after the accept edge have no effect until the next accept.
- Bit counter:
  - Counts 0..latched `baud_div` in every non-IDLE state.
  - `bit_tick` = (state != IDLE) & (counter == latched divisor).
  - On `bit_tick` the counter wraps to 0 and the bit advances.
- Transitions on `bit_tick`:
  - START goes to DATA.
  - DATA stays in DATA until index == length-1, then goes to PARITY if parity is enabled, else to STOP.
  - PARITY goes to STOP.
  - STOP goes to STOP (second stop bit) if `cfg_stop2` and this was the first stop bit. Otherwise it goes to START if a word is accepted at this edge, else to IDLE.
- `tx_line` values per state:
  - START: 0.
  - DATA: `data[index]`.
  - PARITY: XOR of the sent data bits for even parity, its inverse for odd.
  - STOP: 1.
  - IDLE: 1.
- `busy` = (state != IDLE).
- `done` is 1 for exactly one cycle, following the final stop bit's last cycle. This holds whether the next state is IDLE or START.
- Abort: `tx_en`=0 or `tx_rst`=1 at any edge leads to IDLE, `tx_line`=1 and `busy`=0 at that edge.
  - No `done` is produced for the aborted frame.
  - The pending `done` of a frame that has just completed is also cleared.
- If `tx_rst` and accept conditions coincide, `tx_rst` wins. `tx_ready` is already 0 in that case.
- `baud_div`=0 is legal and gives one clock per bit.

## Timing
- Frame length F = (1 + N + P + S)·(D+1) clocks.
  - N is the effective data length.
  - P is 1 if parity is enabled, else 0.
  - S is 1 or 2 stop bits.
  - D is the latched divisor.
- The accept edge is E0.
  - `tx_line` falls at E0, with 0 latency from the handshake.
  - Bit k occupies edges E0+k·(D+1) through E0+(k+1)·(D+1).
- At E0+F:
  - `done` rises for 1 cycle.
  - `busy` falls, unless a new word is accepted at E0+F.
  - `tx_line`=1, unless a new word is accepted at E0+F.
- Back-to-back frames: a word accepted at E0+F starts its START bit at E0+F, with no idle cycle between frames.
- Counter and index widths never overflow. The counter compares for equality against the latched divisor, so it never passes 2^DIV_W−1.

## Test plan
- Reset:
  - Assert `tx_arst_n`=0 mid-frame -> `tx_line`=1, `busy`=0, `done`=0 immediately.
  - Release with `tx_en`=1 -> `tx_ready`=1 in the first cycle.
- 8N1, `baud_div`=3, `tx_data`=0xA5:
  - `tx_line` sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. That is 40 cycles, with 10 `bit_tick`s.
  - `done` pulses at E0+40.
- 7E2, `baud_div`=0, `tx_data`=0x35:
  - `tx_line` sequence is 0,1,0,1,0,1,1,0,0,1,1.
  - Parity bit is 0 (four ones).
  - `done` pulses at E0+11.
- Back-to-back 5O1, `baud_div`=1, `tx_valid` held high with 0x1F then 0x00:
  - First frame: 0,1,1,1,1,1,0,1 (parity bit 0, since five ones is odd).
  - Second START begins at E0+16, coincident with `done`, and `busy` never drops.
  - Second frame parity bit is 1.
- Abort: drop `tx_en` during DATA bit 3 -> `tx_line`=1, `busy`=0 on that edge, and no `done`. Repeat with `tx_rst` for the same result.
- Config isolation:
  - Change `baud_div` from 3 to 9 and `cfg_parity` mid-frame -> the current frame keeps 4-cycle bits and its original parity.
  - The next frame uses the new values.
  - `cfg_data_len`=0 sends DATA_W bits.
